// File: rtl/ysyx_22050019_pipe_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22050019_pipe_ctrl_pkg
//   Shared definitions for the pipeline sequencer and its hazard detector:
//     - pipe_state_e : FSM encodings (RUN=0, MWAIT=1, LU=2, FLUSH=3), which are
//                      also exported on the debug state port
//     - pipe_ctrl_t  : bundle of the six stall/flush enables
//     - CTRL_*       : canned control patterns (idle, freeze, redirect,
//                      fetch-flush, load-use bubble)
//     - REG_ZERO     : architectural x0 index (never a real dependency)
//     - residual_dec : saturating decrement of the 2-bit residual counter
// ----------------------------------------------------------------------------
package ysyx_22050019_pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MWAIT = 2'd1,
        ST_LU    = 2'd2,
        ST_FLUSH = 2'd3
    } pipe_state_e;

    // Field order matches the bit order used for debug dumps:
    // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall}
    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
    } pipe_ctrl_t;

    // Nothing held, nothing cleared.
    localparam pipe_ctrl_t CTRL_IDLE = '0;

    // Data bus wait: every register holds so the whole pipe stays put.
    localparam pipe_ctrl_t CTRL_FREEZE = '{
        pc_stall:     1'b1,
        if_id_stall:  1'b1,
        if_id_flush:  1'b0,
        id_ex_stall:  1'b1,
        id_ex_flush:  1'b0,
        ex_mem_stall: 1'b1
    };

    // Redirect from EX: squash the two younger instructions.
    localparam pipe_ctrl_t CTRL_REDIRECT = '{
        pc_stall:     1'b0,
        if_id_stall:  1'b0,
        if_id_flush:  1'b1,
        id_ex_stall:  1'b0,
        id_ex_flush:  1'b1,
        ex_mem_stall: 1'b0
    };

    // Fetch latency after a redirect: keep feeding nops into IF/ID only.
    localparam pipe_ctrl_t CTRL_FETCH_FLUSH = '{
        pc_stall:     1'b0,
        if_id_stall:  1'b0,
        if_id_flush:  1'b1,
        id_ex_stall:  1'b0,
        id_ex_flush:  1'b0,
        ex_mem_stall: 1'b0
    };

    // Load-use bubble: front end holds, a nop is injected into ID/EX.
    localparam pipe_ctrl_t CTRL_BUBBLE = '{
        pc_stall:     1'b1,
        if_id_stall:  1'b1,
        if_id_flush:  1'b0,
        id_ex_stall:  1'b0,
        id_ex_flush:  1'b1,
        ex_mem_stall: 1'b0
    };

    localparam logic [4:0] REG_ZERO = 5'd0;

    function automatic logic [1:0] residual_dec(input logic [1:0] r);
        return (r == 2'd0) ? 2'd0 : r - 2'd1;
    endfunction

endpackage

// File: rtl/ysyx_22050019_hazard_det.sv
// ----------------------------------------------------------------------------
// ysyx_22050019_hazard_det
//   Combinational load-use detector. Flags when the instruction in ID reads a
//   register that the load currently in EX is about to write.
//   Ports:
//     id_valid_i      ID holds a valid instruction
//     id_rs1_ren_i    ID reads rs1         id_rs1_addr_i  rs1 index
//     id_rs2_ren_i    ID reads rs2         id_rs2_addr_i  rs2 index
//     ex_ram_re_i     EX instruction is a load
//     ex_reg_waddr_i  EX destination register
//     lu_hit_o        load-use hazard present this cycle
// ----------------------------------------------------------------------------
module ysyx_22050019_hazard_det
    import ysyx_22050019_pipe_ctrl_pkg::*;
(
    input  logic       id_valid_i,
    input  logic       id_rs1_ren_i,
    input  logic [4:0] id_rs1_addr_i,
    input  logic       id_rs2_ren_i,
    input  logic [4:0] id_rs2_addr_i,
    input  logic       ex_ram_re_i,
    input  logic [4:0] ex_reg_waddr_i,
    output logic       lu_hit_o
);

    logic rs1_match;
    logic rs2_match;
    logic ex_writes_reg;

    // x0 is hardwired to zero, so a load targeting it creates no dependency.
    assign ex_writes_reg = ex_ram_re_i && (ex_reg_waddr_i != REG_ZERO);

    // Per-operand matches are kept separate so forwarding select can reuse them.
    assign rs1_match = id_rs1_ren_i && (id_rs1_addr_i == ex_reg_waddr_i);
    assign rs2_match = id_rs2_ren_i && (id_rs2_addr_i == ex_reg_waddr_i);

    assign lu_hit_o = id_valid_i && ex_writes_reg && (rs1_match || rs2_match);

endmodule

// File: rtl/ysyx_22050019_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_22050019_pipe_ctrl
//   Pipeline sequencer for the 5-stage core. Produces stall/flush enables for
//   the PC, IF/ID, ID/EX and EX/MEM registers from load-use hazards, EX
//   redirects (branch/jump/trap/mret) and data-bus waits, and keeps saturating
//   stall/flush performance counters.
//   Parameters:
//     LU_BUBBLES   bubbles per load-use hazard (1..3)
//     FLUSH_CYCLES cycles if_id_flush_o is held after a redirect (1..3)
//     CNT_W        performance counter width
//   Ports:
//     clk, rst_n            clock (rising edge), async active-low reset
//     id_*                  ID-stage operand usage
//     ex_ram_re_i           EX is a load       ex_reg_waddr_i EX destination
//     branch_taken_i        EX taken branch    trap_i         EX ecall/mret
//     mem_req_i             MEM bus access     mem_ready_i    bus completes
//     pc_stall_o .. ex_mem_stall_o   stall/flush enables (combinational)
//     state_o               FSM state (debug)
//     stall_cnt_o           cycles with pc_stall_o=1
//     flush_cnt_o           accepted redirects
// ----------------------------------------------------------------------------
module ysyx_22050019_pipe_ctrl
    import ysyx_22050019_pipe_ctrl_pkg::*;
#(
    parameter int LU_BUBBLES   = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid_i,
    input  logic             id_rs1_ren_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic             id_rs2_ren_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             ex_ram_re_i,
    input  logic [4:0]       ex_reg_waddr_i,
    input  logic             branch_taken_i,
    input  logic             trap_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_stall_o,
    output logic             if_id_stall_o,
    output logic             if_id_flush_o,
    output logic             id_ex_stall_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_stall_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // Residual values loaded when entering LU / FLUSH; the entry cycle itself
    // already counts as the first bubble / flush cycle.
    localparam logic [1:0] LU_RES_INIT    = 2'(LU_BUBBLES - 1);
    localparam logic [1:0] FLUSH_RES_INIT = 2'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    pipe_state_e      state_q, state_d;
    pipe_state_e      saved_q, saved_d;
    pipe_state_e      eff_state;
    logic [1:0]       res_q, res_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic             busy;
    logic             redirect;
    logic             lu_hit;
    logic             flush_inc;
    pipe_ctrl_t       ctrl;
    pipe_ctrl_t       ctrl_out;

    ysyx_22050019_hazard_det u_hazard_det (
        .id_valid_i     (id_valid_i),
        .id_rs1_ren_i   (id_rs1_ren_i),
        .id_rs1_addr_i  (id_rs1_addr_i),
        .id_rs2_ren_i   (id_rs2_ren_i),
        .id_rs2_addr_i  (id_rs2_addr_i),
        .ex_ram_re_i    (ex_ram_re_i),
        .ex_reg_waddr_i (ex_reg_waddr_i),
        .lu_hit_o       (lu_hit)
    );

    assign busy     = mem_req_i && !mem_ready_i;
    assign redirect = branch_taken_i || trap_i;

    // While waiting on the bus the FSM sits in MWAIT and remembers what it was
    // doing; once the wait lifts, that saved state is what the rest of the
    // priority chain acts on, in the same cycle the bus completes.
    assign eff_state = (state_q == ST_MWAIT) ? saved_q : state_q;

    // Next-state and control decode. Priority: bus wait, then redirect, then
    // an in-progress flush/bubble sequence, then a fresh load-use hit.
    // A redirect is not accepted while frozen; EX holds the branch so it is
    // seen again when the freeze ends.
    always_comb begin
        ctrl      = CTRL_IDLE;
        state_d   = state_q;
        saved_d   = saved_q;
        res_d     = res_q;
        flush_inc = 1'b0;

        if (busy) begin
            ctrl = CTRL_FREEZE;
            if (state_q != ST_MWAIT) begin
                state_d = ST_MWAIT;
                saved_d = state_q;
            end
        end else if (redirect) begin
            ctrl      = CTRL_REDIRECT;
            flush_inc = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = ST_FLUSH;
                res_d   = FLUSH_RES_INIT;
            end else begin
                state_d = ST_RUN;
                res_d   = 2'd0;
            end
        end else if (eff_state == ST_FLUSH) begin
            ctrl = CTRL_FETCH_FLUSH;
            if (res_q <= 2'd1) begin
                state_d = ST_RUN;
                res_d   = 2'd0;
            end else begin
                state_d = ST_FLUSH;
                res_d   = residual_dec(res_q);
            end
        end else if (eff_state == ST_LU) begin
            ctrl = CTRL_BUBBLE;
            if (res_q <= 2'd1) begin
                state_d = ST_RUN;
                res_d   = 2'd0;
            end else begin
                state_d = ST_LU;
                res_d   = residual_dec(res_q);
            end
        end else if (lu_hit) begin
            ctrl = CTRL_BUBBLE;
            if (LU_BUBBLES > 1) begin
                state_d = ST_LU;
                res_d   = LU_RES_INIT;
            end else begin
                state_d = ST_RUN;
                res_d   = 2'd0;
            end
        end else begin
            state_d = ST_RUN;
            res_d   = 2'd0;
        end
    end

    // Enables are forced low during reset regardless of the inputs, so the
    // pipe registers see a clean idle pattern the moment rst_n drops.
    assign ctrl_out = rst_n ? ctrl : CTRL_IDLE;

    // FSM, residual and saved-state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            saved_q <= ST_RUN;
            res_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            res_q   <= res_d;
        end
    end

    // Saturating performance counters: they stick at all-ones rather than
    // wrapping so a long run never reports a misleadingly small number.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (ctrl_out.pc_stall && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
            if (flush_inc && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end
        end
    end

    assign pc_stall_o     = ctrl_out.pc_stall;
    assign if_id_stall_o  = ctrl_out.if_id_stall;
    assign if_id_flush_o  = ctrl_out.if_id_flush;
    assign id_ex_stall_o  = ctrl_out.id_ex_stall;
    assign id_ex_flush_o  = ctrl_out.id_ex_flush;
    assign ex_mem_stall_o = ctrl_out.ex_mem_stall;
    assign state_o        = state_q;
    assign stall_cnt_o    = stall_cnt_q;
    assign flush_cnt_o    = flush_cnt_q;

endmodule

// File: tb/tb_ysyx_22050019_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22050019_pipe_ctrl
//   Three sequencer instances with different parameter sets share one set of
//   inputs. Each driven cycle, a small behavioural model predicts every
//   instance's enables, state and counters; predictions are queued and
//   compared on the following falling edge.
//     u0 : LU_BUBBLES=1, FLUSH_CYCLES=1, CNT_W=32
//     u1 : LU_BUBBLES=2, FLUSH_CYCLES=3, CNT_W=4
//     u2 : LU_BUBBLES=3, FLUSH_CYCLES=2, CNT_W=8
// ----------------------------------------------------------------------------
module tb_ysyx_22050019_pipe_ctrl;

    localparam int P_LUB [3] = '{1, 2, 3};
    localparam int P_FC  [3] = '{1, 3, 2};
    localparam int P_CW  [3] = '{32, 4, 8};

    // Expected control patterns {pc, ifid_st, ifid_fl, idex_st, idex_fl, exmem}
    localparam logic [5:0] E_IDLE   = 6'b000000;
    localparam logic [5:0] E_FREEZE = 6'b110101;
    localparam logic [5:0] E_REDIR  = 6'b001010;
    localparam logic [5:0] E_FFLUSH = 6'b001000;
    localparam logic [5:0] E_BUBBLE = 6'b110010;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic       rs1_ren;
    logic [4:0] rs1_addr;
    logic       rs2_ren;
    logic [4:0] rs2_addr;
    logic       ex_ram_re;
    logic [4:0] ex_waddr;
    logic       branch_taken;
    logic       trap;
    logic       mem_req;
    logic       mem_ready;

    wire [5:0]  ctrl0, ctrl1, ctrl2;
    wire [1:0]  st0, st1, st2;
    wire [31:0] sc0, fc0;
    wire [3:0]  sc1, fc1;
    wire [7:0]  sc2, fc2;

    typedef struct {
        int          inst;
        logic [5:0]  ctrl;
        logic [1:0]  st;
        logic [63:0] sc;
        logic [63:0] fc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_vectors     = 0;
    int          n_miscompares = 0;
    int          cyc           = 0;

    int          m_wait [3];
    int          m_lu   [3];
    int          m_fl   [3];
    logic [63:0] m_sc   [3];
    logic [63:0] m_fc   [3];

    always #5 clk = ~clk;

    ysyx_22050019_pipe_ctrl #(.LU_BUBBLES(P_LUB[0]), .FLUSH_CYCLES(P_FC[0]), .CNT_W(P_CW[0])) u0 (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid),
        .id_rs1_ren_i(rs1_ren), .id_rs1_addr_i(rs1_addr),
        .id_rs2_ren_i(rs2_ren), .id_rs2_addr_i(rs2_addr),
        .ex_ram_re_i(ex_ram_re), .ex_reg_waddr_i(ex_waddr),
        .branch_taken_i(branch_taken), .trap_i(trap),
        .mem_req_i(mem_req), .mem_ready_i(mem_ready),
        .pc_stall_o(ctrl0[5]), .if_id_stall_o(ctrl0[4]), .if_id_flush_o(ctrl0[3]),
        .id_ex_stall_o(ctrl0[2]), .id_ex_flush_o(ctrl0[1]), .ex_mem_stall_o(ctrl0[0]),
        .state_o(st0), .stall_cnt_o(sc0), .flush_cnt_o(fc0)
    );

    ysyx_22050019_pipe_ctrl #(.LU_BUBBLES(P_LUB[1]), .FLUSH_CYCLES(P_FC[1]), .CNT_W(P_CW[1])) u1 (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid),
        .id_rs1_ren_i(rs1_ren), .id_rs1_addr_i(rs1_addr),
        .id_rs2_ren_i(rs2_ren), .id_rs2_addr_i(rs2_addr),
        .ex_ram_re_i(ex_ram_re), .ex_reg_waddr_i(ex_waddr),
        .branch_taken_i(branch_taken), .trap_i(trap),
        .mem_req_i(mem_req), .mem_ready_i(mem_ready),
        .pc_stall_o(ctrl1[5]), .if_id_stall_o(ctrl1[4]), .if_id_flush_o(ctrl1[3]),
        .id_ex_stall_o(ctrl1[2]), .id_ex_flush_o(ctrl1[1]), .ex_mem_stall_o(ctrl1[0]),
        .state_o(st1), .stall_cnt_o(sc1), .flush_cnt_o(fc1)
    );

    ysyx_22050019_pipe_ctrl #(.LU_BUBBLES(P_LUB[2]), .FLUSH_CYCLES(P_FC[2]), .CNT_W(P_CW[2])) u2 (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid),
        .id_rs1_ren_i(rs1_ren), .id_rs1_addr_i(rs1_addr),
        .id_rs2_ren_i(rs2_ren), .id_rs2_addr_i(rs2_addr),
        .ex_ram_re_i(ex_ram_re), .ex_reg_waddr_i(ex_waddr),
        .branch_taken_i(branch_taken), .trap_i(trap),
        .mem_req_i(mem_req), .mem_ready_i(mem_ready),
        .pc_stall_o(ctrl2[5]), .if_id_stall_o(ctrl2[4]), .if_id_flush_o(ctrl2[3]),
        .id_ex_stall_o(ctrl2[2]), .id_ex_flush_o(ctrl2[1]), .ex_mem_stall_o(ctrl2[0]),
        .state_o(st2), .stall_cnt_o(sc2), .flush_cnt_o(fc2)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 3; k++) begin
            m_wait[k] = 0; m_lu[k] = 0; m_fl[k] = 0; m_sc[k] = '0; m_fc[k] = '0;
        end
    endtask

    // Predict one cycle of instance k from the current inputs, queue the
    // prediction, then advance the model across the coming clock edge.
    task automatic modelStep(input int k);
        exp_t        e;
        logic        busy, redir, hit;
        logic [63:0] maxv;
        maxv   = (64'd1 << P_CW[k]) - 64'd1;
        e.inst = k;
        if (!rst_n) begin
            m_wait[k] = 0; m_lu[k] = 0; m_fl[k] = 0; m_sc[k] = '0; m_fc[k] = '0;
            e.ctrl = E_IDLE; e.st = 2'd0; e.sc = '0; e.fc = '0;
        end else begin
            e.st = (m_wait[k] != 0) ? 2'd1 : (m_fl[k] > 0) ? 2'd3 : (m_lu[k] > 0) ? 2'd2 : 2'd0;
            e.sc = m_sc[k];
            e.fc = m_fc[k];
            busy  = mem_req && !mem_ready;
            redir = branch_taken || trap;
            hit   = id_valid && ex_ram_re && (ex_waddr != 5'd0) &&
                    ((rs1_ren && rs1_addr == ex_waddr) || (rs2_ren && rs2_addr == ex_waddr));
            if (busy) begin
                e.ctrl    = E_FREEZE;
                m_wait[k] = 1;
            end else begin
                m_wait[k] = 0;
                if (redir) begin
                    e.ctrl  = E_REDIR;
                    m_lu[k] = 0;
                    m_fl[k] = P_FC[k] - 1;
                    if (m_fc[k] != maxv) m_fc[k] = m_fc[k] + 1;
                end else if (m_fl[k] > 0) begin
                    e.ctrl  = E_FFLUSH;
                    m_fl[k] = m_fl[k] - 1;
                end else if (m_lu[k] > 0) begin
                    e.ctrl  = E_BUBBLE;
                    m_lu[k] = m_lu[k] - 1;
                end else if (hit) begin
                    e.ctrl  = E_BUBBLE;
                    m_lu[k] = P_LUB[k] - 1;
                end else begin
                    e.ctrl  = E_IDLE;
                end
            end
            if (e.ctrl[5] && m_sc[k] != maxv) m_sc[k] = m_sc[k] + 1;
        end
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs (just after a rising edge), queue predictions,
    // and move on to just after the next rising edge.
    task automatic applyStimulus(input logic v, input logic r1e, input logic [4:0] r1,
                                 input logic r2e, input logic [4:0] r2,
                                 input logic lre, input logic [4:0] wa,
                                 input logic br, input logic tr,
                                 input logic rq, input logic rdy);
        id_valid = v;  rs1_ren = r1e; rs1_addr = r1; rs2_ren = r2e; rs2_addr = r2;
        ex_ram_re = lre; ex_waddr = wa; branch_taken = br; trap = tr;
        mem_req = rq; mem_ready = rdy;
        for (int k = 0; k < 3; k++) modelStep(k);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1);
    endtask

    // EX: lw x<wa>; ID: add x6, x5, x1
    task automatic luHit(input logic [4:0] wa);
        applyStimulus(1, 1, 5'd5, 1, 5'd1, 1, wa, 0, 0, 0, 1);
    endtask

    task automatic busyCycles(input int n, input logic br);
        repeat (n) applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, br, 0, 1, 0);
    endtask

    task automatic compareInst(input exp_t e, input logic [5:0] c, input logic [1:0] s,
                               input logic [63:0] scv, input logic [63:0] fcv);
        checkOutput($sformatf("u%0d.ctrl", e.inst), 64'(c), 64'(e.ctrl));
        checkOutput($sformatf("u%0d.state", e.inst), 64'(s), 64'(e.st));
        checkOutput($sformatf("u%0d.stall_cnt", e.inst), scv, e.sc);
        checkOutput($sformatf("u%0d.flush_cnt", e.inst), fcv, e.fc);
    endtask

    // Scoreboard drain: outputs are sampled mid-cycle, away from the edge.
    always @(negedge clk) begin
        while (sb.size() != 0) begin
            mon_e = sb.pop_front();
            case (mon_e.inst)
                0:       compareInst(mon_e, ctrl0, st0, 64'(sc0), 64'(fc0));
                1:       compareInst(mon_e, ctrl1, st1, 64'(sc1), 64'(fc1));
                default: compareInst(mon_e, ctrl2, st2, 64'(sc2), 64'(fc2));
            endcase
        end
    end

    // Drop reset in the middle of a cycle while hazard inputs stay active:
    // everything must go to zero without waiting for a clock edge.
    task automatic asyncResetCheck();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("u0.rst_ctrl", 64'(ctrl0), 64'(E_IDLE));
        checkOutput("u1.rst_ctrl", 64'(ctrl1), 64'(E_IDLE));
        checkOutput("u2.rst_ctrl", 64'(ctrl2), 64'(E_IDLE));
        checkOutput("u2.rst_state", 64'(st2), 64'd0);
        checkOutput("u2.rst_stall_cnt", 64'(sc2), 64'd0);
        checkOutput("u1.rst_flush_cnt", 64'(fc1), 64'd0);
        modelReset();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        id_valid = 0; rs1_ren = 0; rs1_addr = 0; rs2_ren = 0; rs2_addr = 0;
        ex_ram_re = 0; ex_waddr = 0; branch_taken = 0; trap = 0;
        mem_req = 0; mem_ready = 1;
        modelReset();
        @(posedge clk);
        #1;

        $display("[TB] reset with hazard inputs active");
        repeat (2) luHit(5'd5);
        rst_n = 1'b1;

        $display("[TB] load-use hazards");
        luHit(5'd5);
        idle(4);
        applyStimulus(1, 1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0, 1);   // waddr x0
        idle(1);
        applyStimulus(1, 0, 5'd7, 1, 5'd7, 1, 5'd7, 0, 0, 0, 1);   // rs2 match
        idle(4);
        applyStimulus(0, 1, 5'd5, 1, 5'd1, 1, 5'd5, 0, 0, 0, 1);   // ID not valid
        applyStimulus(1, 0, 5'd5, 0, 5'd5, 1, 5'd5, 0, 0, 0, 1);   // no reads
        applyStimulus(1, 1, 5'd5, 1, 5'd1, 0, 5'd5, 0, 0, 0, 1);   // EX not a load
        idle(1);

        $display("[TB] redirects");
        applyStimulus(1, 1, 5'd5, 1, 5'd1, 1, 5'd5, 1, 0, 0, 1);   // branch + lu_hit
        idle(4);
        applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 1);   // trap
        idle(1);
        applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 1);   // redirect inside FLUSH
        idle(4);
        luHit(5'd5);
        applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 1);   // redirect aborts LU
        idle(4);

        $display("[TB] memory wait with pending branch");
        busyCycles(4, 1'b1);
        applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 1, 1);   // bus completes
        idle(4);

        $display("[TB] freeze during load-use bubbles");
        luHit(5'd5);
        busyCycles(3, 1'b0);
        idle(4);
        applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 1);
        busyCycles(2, 1'b0);
        idle(4);

        $display("[TB] async reset in the middle of a bubble sequence");
        luHit(5'd5);
        asyncResetCheck();
        repeat (2) luHit(5'd5);
        rst_n = 1'b1;
        luHit(5'd5);
        idle(4);

        $display("[TB] counter saturation");
        busyCycles(20, 1'b0);
        idle(1);
        checkOutput("u1.stall_sat", 64'(sc1), 64'hF);
        busyCycles(3, 1'b0);
        idle(1);
        checkOutput("u1.stall_sat_hold", 64'(sc1), 64'hF);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0),
                          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end
        idle(4);

        @(negedge clk);
        #1;
        checkOutput("sb.drain", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
